// File: rtl/fuzzy_seq_pkg.sv
// Shared types, widths and the input clamp for the fuzzy sweep sequencer.
package fuzzy_seq_pkg;

    localparam int unsigned IDX_W = 9;
    localparam int unsigned IN_W  = 8;
    localparam int unsigned FOU_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST_CORE,
        ST_SETTLE,
        ST_HOLD,
        ST_DONE
    } seq_state_e;

    typedef struct packed {
        logic [IN_W-1:0]  data;
        logic [FOU_W-1:0] fou;
        logic [IDX_W-1:0] i;
        logic [IDX_W-1:0] j;
    } seq_result_t;

    // Map a raw grid index onto the range the core accepts.
    function automatic logic [IN_W-1:0] clamp(input logic [IDX_W-1:0] v,
                                              input logic [IN_W-1:0]  lo,
                                              input logic [IN_W-1:0]  hi);
        if (v < IDX_W'(lo))      return lo;
        else if (v > IDX_W'(hi)) return hi;
        else                     return v[IN_W-1:0];
    endfunction

endpackage

// File: rtl/fuzzy_sweep_sequencer_if.sv
// Core drive/sample signals plus the result valid/ready stream.
interface fuzzy_sweep_sequencer_if;
    import fuzzy_seq_pkg::*;

    logic [IN_W-1:0]  Entrada_01;
    logic [IN_W-1:0]  Entrada_02;
    logic             EN_REGRAS;
    logic             rst_fuzzy;
    logic [IN_W-1:0]  saida_defuzzy;
    logic [FOU_W-1:0] FOU_ATIVO;
    logic             res_valid;
    logic             res_ready;
    logic [IN_W-1:0]  res_data;
    logic [FOU_W-1:0] res_fou;
    logic [IDX_W-1:0] res_i;
    logic [IDX_W-1:0] res_j;

    modport master (
        output Entrada_01, Entrada_02, EN_REGRAS, rst_fuzzy,
        output res_valid, res_data, res_fou, res_i, res_j,
        input  saida_defuzzy, FOU_ATIVO, res_ready
    );

    modport slave (
        input  Entrada_01, Entrada_02, EN_REGRAS, rst_fuzzy,
        input  res_valid, res_data, res_fou, res_i, res_j,
        output saida_defuzzy, FOU_ATIVO, res_ready
    );

endinterface

// File: rtl/fuzzy_grid_counter.sv
// Raster index pair (j inner, i outer) with look-ahead next point and last-point flag.
module fuzzy_grid_counter
    import fuzzy_seq_pkg::*;
#(
    parameter int unsigned STEP  = 1,
    parameter int unsigned LIMIT = 255
) (
    input  logic             clk_0,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    output logic [IDX_W-1:0] i,
    output logic [IDX_W-1:0] j,
    output logic [IDX_W-1:0] i_next_c,
    output logic [IDX_W-1:0] j_next_c,
    output logic             last_c
);

    localparam int unsigned SUM_W = IDX_W + 1;
    localparam logic [SUM_W-1:0] STEP_W  = SUM_W'(STEP);
    localparam logic [SUM_W-1:0] LIMIT_W = SUM_W'(LIMIT);

    logic [SUM_W-1:0] i_sum;
    logic [SUM_W-1:0] j_sum;
    logic             j_wrap;

    // One extra bit so index + STEP never wraps before the LIMIT compare.
    assign i_sum  = {1'b0, i} + STEP_W;
    assign j_sum  = {1'b0, j} + STEP_W;
    assign j_wrap = (j_sum >= LIMIT_W);
    assign last_c = (i_sum >= LIMIT_W) && j_wrap;

    always_comb begin
        i_next_c = i;
        j_next_c = j_sum[IDX_W-1:0];
        if (j_wrap) begin
            j_next_c = '0;
            i_next_c = i_sum[IDX_W-1:0];
        end
    end

    always_ff @(posedge clk_0) begin
        if (rst || clear) begin
            i <= '0;
            j <= '0;
        end else if (advance) begin
            i <= i_next_c;
            j <= j_next_c;
        end
    end

endmodule

// File: rtl/fuzzy_sweep_sequencer.sv
// Sweeps the fuzzy core over a 2-D input grid and streams one sampled result per point.
module fuzzy_sweep_sequencer
    import fuzzy_seq_pkg::*;
#(
    parameter int unsigned STEP          = 1,
    parameter int unsigned LIMIT         = 255,
    parameter int unsigned IN_MIN        = 1,
    parameter int unsigned IN_MAX        = 254,
    parameter int unsigned SETTLE_CYCLES = 21,
    parameter int unsigned RST_CYCLES    = 2
) (
    input  logic clk_0,
    input  logic Srst,
    input  logic start,
    input  logic abort,
    output logic busy,
    output logic done,
    fuzzy_sweep_sequencer_if.master bus
);

    localparam int unsigned RST_W = $clog2(RST_CYCLES + 1);
    localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [IN_W-1:0]  LO = IN_W'(IN_MIN);
    localparam logic [IN_W-1:0]  HI = IN_W'(IN_MAX);

    seq_state_e       state;
    logic [RST_W-1:0] rst_cnt;
    logic [SET_W-1:0] settle_cnt;
    logic [IN_W-1:0]  in_1;
    logic [IN_W-1:0]  in_2;
    logic             en_regras;
    logic             rst_core;
    logic             res_valid_q;
    seq_result_t      res_q;

    logic [IDX_W-1:0] i;
    logic [IDX_W-1:0] j;
    logic [IDX_W-1:0] i_next_c;
    logic [IDX_W-1:0] j_next_c;
    logic             last_c;
    logic             active_c;
    logic             abort_c;
    logic             grid_clear_c;
    logic             grid_adv_c;

    assign active_c = (state inside {ST_RST_CORE, ST_SETTLE, ST_HOLD});
    assign abort_c  = abort && active_c;

    // Grid index control mirrors the FSM edges that restart or step the sweep.
    always_comb begin
        grid_clear_c = 1'b0;
        grid_adv_c   = 1'b0;
        if (abort_c) begin
            grid_clear_c = 1'b1;
        end else if ((state == ST_IDLE || state == ST_DONE) && start) begin
            grid_clear_c = 1'b1;
        end else if (state == ST_HOLD && bus.res_ready && !last_c) begin
            grid_adv_c = 1'b1;
        end
    end

    fuzzy_grid_counter #(
        .STEP  (STEP),
        .LIMIT (LIMIT)
    ) u_grid (
        .clk_0    (clk_0),
        .rst      (Srst),
        .clear    (grid_clear_c),
        .advance  (grid_adv_c),
        .i        (i),
        .j        (j),
        .i_next_c (i_next_c),
        .j_next_c (j_next_c),
        .last_c   (last_c)
    );

    always_ff @(posedge clk_0) begin
        if (Srst) begin
            state       <= ST_IDLE;
            rst_cnt     <= '0;
            settle_cnt  <= '0;
            in_1        <= '0;
            in_2        <= '0;
            en_regras   <= 1'b0;
            rst_core    <= 1'b1;
            res_valid_q <= 1'b0;
            res_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else if (abort_c) begin
            state       <= ST_IDLE;
            res_valid_q <= 1'b0;
            rst_core    <= 1'b1;
            en_regras   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state   <= ST_RST_CORE;
                        rst_cnt <= '0;
                        done    <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                ST_RST_CORE: begin
                    if (rst_cnt == RST_LAST) begin
                        in_1       <= clamp(i, LO, HI);
                        in_2       <= clamp(j, LO, HI);
                        rst_core   <= 1'b0;
                        en_regras  <= 1'b1;
                        settle_cnt <= '0;
                        state      <= ST_SETTLE;
                    end else begin
                        rst_cnt <= rst_cnt + RST_W'(1);
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == SET_LAST) begin
                        res_q.data  <= bus.saida_defuzzy;
                        res_q.fou   <= bus.FOU_ATIVO;
                        res_q.i     <= i;
                        res_q.j     <= j;
                        res_valid_q <= 1'b1;
                        state       <= ST_HOLD;
                    end else begin
                        settle_cnt <= settle_cnt + SET_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        if (last_c) begin
                            state     <= ST_DONE;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            en_regras <= 1'b0;
                            rst_core  <= 1'b1;
                        end else begin
                            // Next point's inputs go out on the accepting edge.
                            in_1       <= clamp(i_next_c, LO, HI);
                            in_2       <= clamp(j_next_c, LO, HI);
                            settle_cnt <= '0;
                            state      <= ST_SETTLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.Entrada_01 = in_1;
    assign bus.Entrada_02 = in_2;
    assign bus.EN_REGRAS  = en_regras;
    assign bus.rst_fuzzy  = rst_core;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_data   = res_q.data;
    assign bus.res_fou    = res_q.fou;
    assign bus.res_i      = res_q.i;
    assign bus.res_j      = res_q.j;

endmodule

// File: tb/tb_fuzzy_sweep_sequencer.sv
// Directed bench: small 3x3 sweep instance and a STEP=16 clamp-boundary instance.
module tb_fuzzy_sweep_sequencer;

    logic clk_0 = 1'b0;
    always #5 clk_0 = ~clk_0;

    logic Srst    = 1'b1;
    logic start_a = 1'b0, abort_a = 1'b0, ready_a = 1'b1;
    logic start_b = 1'b0, abort_b = 1'b0, ready_b = 1'b1;
    logic busy_a, done_a, busy_b, done_b;

    int total = 0;
    int bad   = 0;

    int exp_data_a [9] = '{2, 2, 3, 2, 2, 3, 3, 3, 4};

    fuzzy_sweep_sequencer_if bus_a ();
    fuzzy_sweep_sequencer_if bus_b ();

    // Core stubs: output = sum of inputs, FOU = low bits of input 2.
    assign bus_a.saida_defuzzy = bus_a.Entrada_01 + bus_a.Entrada_02;
    assign bus_a.FOU_ATIVO     = bus_a.Entrada_02[5:0];
    assign bus_a.res_ready     = ready_a;
    assign bus_b.saida_defuzzy = bus_b.Entrada_01 + bus_b.Entrada_02;
    assign bus_b.FOU_ATIVO     = bus_b.Entrada_02[5:0];
    assign bus_b.res_ready     = ready_b;

    fuzzy_sweep_sequencer #(
        .STEP(1), .LIMIT(3), .IN_MIN(1), .IN_MAX(254), .SETTLE_CYCLES(4), .RST_CYCLES(2)
    ) dut_a (
        .clk_0(clk_0), .Srst(Srst), .start(start_a), .abort(abort_a),
        .busy(busy_a), .done(done_a), .bus(bus_a)
    );

    fuzzy_sweep_sequencer #(
        .STEP(16), .LIMIT(257), .IN_MIN(1), .IN_MAX(254), .SETTLE_CYCLES(3), .RST_CYCLES(1)
    ) dut_b (
        .clk_0(clk_0), .Srst(Srst), .start(start_b), .abort(abort_b),
        .busy(busy_b), .done(done_b), .bus(bus_b)
    );

    function automatic logic [7:0] tb_clamp(input int v);
        logic [7:0] r;
        if (v < 1)        r = 8'd1;
        else if (v > 254) r = 8'd254;
        else              r = 8'(v);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk_0);
        #1;
    endtask

    task automatic test_reset();
        Srst = 1'b1;
        tick();
        tick();
        total++; if (bus_a.rst_fuzzy !== 1'b1) begin bad++; $display("FAIL reset_rst_fuzzy got=%b exp=1", bus_a.rst_fuzzy); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
        total++; if (bus_a.res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%b exp=0", bus_a.res_valid); end
        total++; if (done_a !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done_a); end
        total++; if (bus_a.Entrada_01 !== 8'd0 || bus_a.Entrada_02 !== 8'd0) begin bad++; $display("FAIL reset_entrada got=%0d,%0d exp=0,0", bus_a.Entrada_01, bus_a.Entrada_02); end
        total++; if (bus_a.EN_REGRAS !== 1'b0) begin bad++; $display("FAIL reset_en_regras got=%b exp=0", bus_a.EN_REGRAS); end
        total++; if (bus_b.rst_fuzzy !== 1'b1 || busy_b !== 1'b0) begin bad++; $display("FAIL reset_b got rst=%b busy=%b exp 1,0", bus_b.rst_fuzzy, busy_b); end
        Srst = 1'b0;
    endtask

    // Full 3x3 sweep with a stray start pulse during the first SETTLE.
    task automatic test_sweep();
        logic exp_v;
        int   idx;
        logic [7:0] e2;
        ready_a = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL sweep_busy got=%b exp=1", busy_a); end
        for (int n = 1; n <= 47; n++) begin
            start_a = (n == 4);
            tick();
            if (n == 1) begin
                total++; if (bus_a.rst_fuzzy !== 1'b1) begin bad++; $display("FAIL sweep_rst_hold got=%b exp=1", bus_a.rst_fuzzy); end
            end
            if (n == 2) begin
                total++; if (bus_a.rst_fuzzy !== 1'b0 || bus_a.EN_REGRAS !== 1'b1) begin bad++; $display("FAIL sweep_rst_release got rst=%b en=%b exp 0,1", bus_a.rst_fuzzy, bus_a.EN_REGRAS); end
            end
            exp_v = (n >= 6) && (((n - 6) % 5) == 0) && (((n - 6) / 5) < 9);
            total++; if (bus_a.res_valid !== exp_v) begin bad++; $display("FAIL sweep_valid n=%0d got=%b exp=%b", n, bus_a.res_valid, exp_v); end
            if (exp_v && bus_a.res_valid === 1'b1) begin
                idx = (n - 6) / 5;
                e2  = tb_clamp(idx % 3);
                total++; if (bus_a.res_i !== 9'(idx / 3) || bus_a.res_j !== 9'(idx % 3)) begin bad++; $display("FAIL sweep_index k=%0d got=(%0d,%0d) exp=(%0d,%0d)", idx, bus_a.res_i, bus_a.res_j, idx / 3, idx % 3); end
                total++; if (bus_a.res_data !== 8'(exp_data_a[idx])) begin bad++; $display("FAIL sweep_data k=%0d got=%0d exp=%0d", idx, bus_a.res_data, exp_data_a[idx]); end
                total++; if (bus_a.res_fou !== e2[5:0]) begin bad++; $display("FAIL sweep_fou k=%0d got=%0d exp=%0d", idx, bus_a.res_fou, e2[5:0]); end
                total++; if (bus_a.Entrada_01 !== tb_clamp(idx / 3)) begin bad++; $display("FAIL sweep_entrada1 k=%0d got=%0d exp=%0d", idx, bus_a.Entrada_01, tb_clamp(idx / 3)); end
            end
        end
        start_a = 1'b0;
        total++; if (done_a !== 1'b1) begin bad++; $display("FAIL sweep_done got=%b exp=1", done_a); end
        total++; if (busy_a !== 1'b0 || bus_a.rst_fuzzy !== 1'b1 || bus_a.EN_REGRAS !== 1'b0) begin bad++; $display("FAIL sweep_done_outputs got busy=%b rst=%b en=%b exp 0,1,0", busy_a, bus_a.rst_fuzzy, bus_a.EN_REGRAS); end
    endtask

    task automatic test_abort_in_done();
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        total++; if (done_a !== 1'b1 || busy_a !== 1'b0) begin bad++; $display("FAIL done_abort got done=%b busy=%b exp 1,0", done_a, busy_a); end
    endtask

    task automatic test_done_restart();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        total++; if (done_a !== 1'b0 || busy_a !== 1'b1) begin bad++; $display("FAIL restart_flags got done=%b busy=%b exp 0,1", done_a, busy_a); end
        for (int n = 1; n <= 6; n++) begin
            tick();
            total++; if (bus_a.res_valid !== (n == 6)) begin bad++; $display("FAIL restart_valid n=%0d got=%b exp=%b", n, bus_a.res_valid, (n == 6)); end
        end
        total++; if (bus_a.res_i !== 9'd0 || bus_a.res_j !== 9'd0) begin bad++; $display("FAIL restart_first got=(%0d,%0d) exp=(0,0)", bus_a.res_i, bus_a.res_j); end
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        total++; if (busy_a !== 1'b0 || bus_a.res_valid !== 1'b0) begin bad++; $display("FAIL restart_abort got busy=%b valid=%b exp 0,0", busy_a, bus_a.res_valid); end
    endtask

    task automatic test_backpressure();
        ready_a = 1'b0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int n = 1; n <= 6; n++) tick();
        total++; if (bus_a.res_valid !== 1'b1) begin bad++; $display("FAIL bp_first_valid got=%b exp=1", bus_a.res_valid); end
        for (int c = 0; c < 10; c++) begin
            tick();
            total++;
            if (bus_a.res_valid !== 1'b1 || bus_a.res_data !== 8'd2 || bus_a.res_i !== 9'd0 || bus_a.res_j !== 9'd0 ||
                bus_a.Entrada_01 !== 8'd1 || bus_a.Entrada_02 !== 8'd1) begin
                bad++;
                $display("FAIL bp_hold c=%0d got v=%b d=%0d i=%0d j=%0d e=%0d,%0d exp 1,2,0,0,1,1", c, bus_a.res_valid,
                         bus_a.res_data, bus_a.res_i, bus_a.res_j, bus_a.Entrada_01, bus_a.Entrada_02);
            end
        end
        ready_a = 1'b1;
        tick();
        total++; if (bus_a.res_valid !== 1'b0) begin bad++; $display("FAIL bp_accept got=%b exp=0", bus_a.res_valid); end
        for (int n = 1; n <= 4; n++) tick();
        total++; if (bus_a.res_valid !== 1'b1 || bus_a.res_i !== 9'd0 || bus_a.res_j !== 9'd1) begin bad++; $display("FAIL bp_next got v=%b (%0d,%0d) exp 1 (0,1)", bus_a.res_valid, bus_a.res_i, bus_a.res_j); end
        // Abort wins over the simultaneous handshake.
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        total++; if (busy_a !== 1'b0 || bus_a.res_valid !== 1'b0 || bus_a.rst_fuzzy !== 1'b1 || bus_a.EN_REGRAS !== 1'b0) begin bad++; $display("FAIL bp_abort got busy=%b v=%b rst=%b en=%b exp 0,0,1,0", busy_a, bus_a.res_valid, bus_a.rst_fuzzy, bus_a.EN_REGRAS); end
    endtask

    task automatic test_abort();
        ready_a = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int n = 1; n <= 23; n++) begin
            tick();
            if (n == 21) begin
                total++; if (bus_a.res_valid !== 1'b1 || bus_a.res_i !== 9'd1 || bus_a.res_j !== 9'd0) begin bad++; $display("FAIL abort_pre got v=%b (%0d,%0d) exp 1 (1,0)", bus_a.res_valid, bus_a.res_i, bus_a.res_j); end
            end
        end
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        total++; if (busy_a !== 1'b0 || bus_a.res_valid !== 1'b0 || bus_a.rst_fuzzy !== 1'b1 || bus_a.EN_REGRAS !== 1'b0) begin bad++; $display("FAIL abort_idle got busy=%b v=%b rst=%b en=%b exp 0,0,1,0", busy_a, bus_a.res_valid, bus_a.rst_fuzzy, bus_a.EN_REGRAS); end
        for (int n = 0; n < 6; n++) begin
            tick();
            total++; if (bus_a.res_valid !== 1'b0) begin bad++; $display("FAIL abort_quiet n=%0d got=%b exp=0", n, bus_a.res_valid); end
        end
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int n = 1; n <= 6; n++) tick();
        total++; if (bus_a.res_valid !== 1'b1 || bus_a.res_i !== 9'd0 || bus_a.res_j !== 9'd0) begin bad++; $display("FAIL abort_restart got v=%b (%0d,%0d) exp 1 (0,0)", bus_a.res_valid, bus_a.res_i, bus_a.res_j); end
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
    endtask

    task automatic test_reset_mid();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int n = 1; n <= 8; n++) tick();
        Srst = 1'b1;
        tick();
        Srst = 1'b0;
        total++; if (busy_a !== 1'b0 || bus_a.rst_fuzzy !== 1'b1 || bus_a.res_valid !== 1'b0 || bus_a.EN_REGRAS !== 1'b0) begin bad++; $display("FAIL srst_mid got busy=%b rst=%b v=%b en=%b exp 0,1,0,0", busy_a, bus_a.rst_fuzzy, bus_a.res_valid, bus_a.EN_REGRAS); end
        total++; if (bus_a.Entrada_01 !== 8'd0 || bus_a.Entrada_02 !== 8'd0) begin bad++; $display("FAIL srst_mid_entrada got=%0d,%0d exp=0,0", bus_a.Entrada_01, bus_a.Entrada_02); end
        for (int n = 0; n < 8; n++) begin
            tick();
            total++; if (bus_a.res_valid !== 1'b0) begin bad++; $display("FAIL srst_mid_quiet n=%0d got=%b exp=0", n, bus_a.res_valid); end
        end
    endtask

    // STEP=16 over LIMIT=257: 17x17 points, indices up to 256 hit the upper clamp.
    task automatic test_step16();
        int ei, ej, cnt, hi_seen;
        logic [7:0] ed;
        ei = 0; ej = 0; cnt = 0; hi_seen = 0;
        ready_b = 1'b1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int n = 0; n < 2000 && done_b !== 1'b1; n++) begin
            tick();
            if (bus_b.res_valid === 1'b1) begin
                ed = tb_clamp(ei) + tb_clamp(ej);
                total++; if (bus_b.res_i !== 9'(ei) || bus_b.res_j !== 9'(ej)) begin bad++; $display("FAIL s16_index k=%0d got=(%0d,%0d) exp=(%0d,%0d)", cnt, bus_b.res_i, bus_b.res_j, ei, ej); end
                total++; if (bus_b.res_data !== ed) begin bad++; $display("FAIL s16_data k=%0d got=%0d exp=%0d", cnt, bus_b.res_data, ed); end
                total++; if (bus_b.Entrada_01 !== tb_clamp(ei) || bus_b.Entrada_02 !== tb_clamp(ej)) begin bad++; $display("FAIL s16_entrada k=%0d got=%0d,%0d exp=%0d,%0d", cnt, bus_b.Entrada_01, bus_b.Entrada_02, tb_clamp(ei), tb_clamp(ej)); end
                if (ei == 256 && ej == 0) begin
                    hi_seen = 1;
                    total++; if (bus_b.Entrada_01 !== 8'd254) begin bad++; $display("FAIL s16_clamp_hi got=%0d exp=254", bus_b.Entrada_01); end
                end
                if (ei == 0 && ej == 0) begin
                    total++; if (bus_b.Entrada_01 !== 8'd1) begin bad++; $display("FAIL s16_clamp_lo got=%0d exp=1", bus_b.Entrada_01); end
                end
                cnt++;
                if (ej + 16 >= 257) begin ej = 0; ei = ei + 16; end
                else ej = ej + 16;
            end
        end
        total++; if (done_b !== 1'b1) begin bad++; $display("FAIL s16_timeout got done=%b exp=1", done_b); end
        total++; if (cnt != 289) begin bad++; $display("FAIL s16_count got=%0d exp=289", cnt); end
        total++; if (hi_seen != 1) begin bad++; $display("FAIL s16_row256 got=%0d exp=1", hi_seen); end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_abort_in_done();
        test_done_restart();
        test_backpressure();
        test_abort();
        test_reset_mid();
        test_step16();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
